// File: rtl/psram_opi_resp.sv
// OPI DDR PSRAM responder: oversamples the psram bus on clk_i and serves byte/MR reads and writes.
// Optional build macro PSRAM_RESP_DQS_MASK_EN: DQS high during a data-write beat masks that byte.
module psram_opi_resp #(
   parameter int         MEM_BYTES  = 1024*1024,
   parameter logic [7:0] RD_LAT_DEF = 8'd5,
   parameter logic [7:0] WR_LAT_DEF = 8'd5
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       psram_sck_i,
   input  logic       psram_ce_i,
   input  logic [7:0] psram_io_in_i,
   output logic [7:0] psram_io_out_o,
   output logic       psram_io_en_o,
   input  logic       psram_dqs_in_i,
   output logic       psram_dqs_out_o,
   output logic       psram_dqs_en_o,
   output logic       busy_o
);
   localparam int AW = $clog2(MEM_BYTES);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_LAT, S_RDATA, S_WDATA, S_IGNORE
   } state_t;

   state_t          state, state_nxt;
   logic            sck_p0, sck_p1, sck_p2;
   logic            ce_p0, ce_p1, ce_p2;
   logic            dqs_p0, dqs_p1;
   logic [7:0]      io_p0, io_p1;
   logic [2:0]      cnt;
   logic [8:0]      lat_cnt, lat_sel;
   logic [7:0]      op_r;
   logic [AW-1:0]   addr_r, addr_full, ptr;
   logic [7:0]      mr [8];
   logic [7:0]      mem [MEM_BYTES];
   logic            mr_done, wr_mask, mem_we;
   logic            sck_edge, ce_rise, ce_fall, beat;
   logic            is_read, is_mr, op_ok, addr_done, enter_rd;
   state_t          data_st;

   function automatic logic [2:0] sat_inc(input logic [2:0] v);
      return (v == 3'd7) ? v : v + 3'd1;
   endfunction

   function automatic logic [8:0] sat_dec(input logic [8:0] v);
      return (v == 9'd0) ? v : v - 9'd1;
   endfunction

   function automatic logic [7:0] mr_reset_val(input int idx);
      case (idx)
         0:       return RD_LAT_DEF;
         1:       return 8'h0D;
         4:       return WR_LAT_DEF;
         default: return 8'h00;
      endcase
   endfunction

   // p0 -> p1: two-flop synchronizer; p2 holds the previous synced value for edge detection
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sck_p0 <= 1'b0; sck_p1 <= 1'b0; sck_p2 <= 1'b0;
         ce_p0  <= 1'b1; ce_p1  <= 1'b1; ce_p2  <= 1'b1;
         dqs_p0 <= 1'b0; dqs_p1 <= 1'b0;
      end else begin
         sck_p0 <= psram_sck_i;  sck_p1 <= sck_p0;  sck_p2 <= sck_p1;
         ce_p0  <= psram_ce_i;   ce_p1  <= ce_p0;   ce_p2  <= ce_p1;
         dqs_p0 <= psram_dqs_in_i; dqs_p1 <= dqs_p0;
      end
   end

   always_ff @(posedge clk_i) begin
      io_p0 <= psram_io_in_i;
      io_p1 <= io_p0;
   end

   assign sck_edge  = sck_p1 ^ sck_p2;
   assign ce_rise   = ce_p1 & ~ce_p2;
   assign ce_fall   = ~ce_p1 & ce_p2;
   assign beat      = sck_edge & ~ce_rise;

   assign is_read   = (op_r == 8'h00) || (op_r == 8'h40);
   assign is_mr     = (op_r == 8'h40) || (op_r == 8'hC0);
   assign op_ok     = is_read || (op_r == 8'h80) || (op_r == 8'hC0);
   assign data_st   = is_read ? S_RDATA : S_WDATA;
   assign lat_sel   = is_read ? {mr[0], 1'b0} : {mr[4], 1'b0};
   assign addr_full = AW'({addr_r, io_p1});
   assign busy_o    = (state != S_IDLE);

`ifdef PSRAM_RESP_DQS_MASK_EN
   assign wr_mask = dqs_p1;
`else
   logic unused_dqs;
   assign wr_mask    = 1'b0;
   assign unused_dqs = dqs_p1;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      addr_done = 1'b0;
      if (ce_rise) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: if (ce_fall) state_nxt = S_CMD;
            S_CMD:  if (beat && cnt == 3'd1) state_nxt = op_ok ? S_ADDR : S_IGNORE;
            S_ADDR: if (beat && cnt == 3'd3) begin
               addr_done = 1'b1;
               state_nxt = (lat_sel == 9'd0) ? data_st : S_LAT;
            end
            S_LAT:  if (beat && lat_cnt <= 9'd1) state_nxt = data_st;
            default: ;
         endcase
      end
   end

   assign enter_rd = (state_nxt == S_RDATA) && (state != S_RDATA);
   assign mem_we   = !rst_i && (state == S_WDATA) && beat && !is_mr && !wr_mask;

   // control stage: counters, MRs and registered bus outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt             <= 3'd0;
         lat_cnt         <= 9'd0;
         mr_done         <= 1'b0;
         psram_io_out_o  <= 8'h00;
         psram_io_en_o   <= 1'b0;
         psram_dqs_out_o <= 1'b0;
         psram_dqs_en_o  <= 1'b0;
         for (int i = 0; i < 8; i++) mr[i] <= mr_reset_val(i);
      end else begin
         if (state_nxt != state) cnt <= 3'd0;
         else if (beat)          cnt <= sat_inc(cnt);

         if (addr_done)                  lat_cnt <= lat_sel;
         else if (state == S_LAT && beat) lat_cnt <= sat_dec(lat_cnt);

         if (addr_done) mr_done <= 1'b0;
         else if (state == S_WDATA && beat && is_mr && !mr_done) begin
            mr_done <= 1'b1;
            if (addr_r[2:0] != 3'd1) mr[addr_r[2:0]] <= io_p1;
         end

         if (ce_rise) begin
            psram_io_en_o   <= 1'b0;
            psram_dqs_en_o  <= 1'b0;
            psram_dqs_out_o <= 1'b0;
         end else if (enter_rd) begin
            psram_io_en_o   <= 1'b1;
            psram_dqs_en_o  <= 1'b1;
            psram_dqs_out_o <= 1'b0;
         end else if (state == S_RDATA && beat) begin
            psram_io_out_o  <= is_mr ? mr[addr_r[2:0]] : mem[ptr];
            psram_dqs_out_o <= ~psram_dqs_out_o;
         end
      end
   end

   // data stage: opcode, address and burst pointer
   always_ff @(posedge clk_i) begin
      if (state == S_CMD && beat && cnt == 3'd0) op_r <= io_p1;
      if (state == S_ADDR && beat)               addr_r <= addr_full;
      if (addr_done)
         ptr <= addr_full;
      else if ((state == S_RDATA || state == S_WDATA) && beat && !is_mr)
         ptr <= ptr + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (mem_we) mem[ptr] <= io_p1;
   end

endmodule

// File: tb/tb_psram_opi_resp.sv
// Bench for psram_opi_resp: directed bus transactions plus randomized write/read-back against a byte-array model.
module tb_psram_opi_resp;
   localparam int MB = 1024;

   logic       clk = 1'b0, rst = 1'b1;
   logic       sck = 1'b0, ce = 1'b1, dqs_in = 1'b0;
   logic [7:0] io_in = 8'h00;
   logic [7:0] io_out;
   logic       io_en, dqs_out, dqs_en, busy;

   int errors = 0, checks = 0;
   logic [7:0] mem_m [MB];
   bit         wr_m  [MB];
   logic [7:0] mr_m  [8];
   logic [7:0] wbuf  [16];
   bit         mbuf  [16];

   always #5 clk = ~clk;

   psram_opi_resp #(.MEM_BYTES(MB)) dut (
      .clk_i(clk), .rst_i(rst), .psram_sck_i(sck), .psram_ce_i(ce),
      .psram_io_in_i(io_in), .psram_io_out_o(io_out), .psram_io_en_o(io_en),
      .psram_dqs_in_i(dqs_in), .psram_dqs_out_o(dqs_out), .psram_dqs_en_o(dqs_en),
      .busy_o(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_mr_reset();
      for (int i = 0; i < 8; i++) mr_m[i] = 8'h00;
      mr_m[0] = 8'h05; mr_m[1] = 8'h0D; mr_m[4] = 8'h05;
   endtask

   task automatic beat(input logic [7:0] b, input bit m);
      @(negedge clk);
      io_in = b; dqs_in = m; sck = ~sck;
      repeat (3) @(negedge clk);
   endtask

   task automatic start(input logic [7:0] op, input logic [31:0] a);
      @(negedge clk);
      ce = 1'b0;
      repeat (3) @(negedge clk);
      chk("busy_start", busy, 1);
      beat(op, 0); beat(8'h00, 0);
      for (int i = 3; i >= 0; i--) beat(a[8*i +: 8], 0);
   endtask

   task automatic finish();
      @(negedge clk);
      ce = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
      repeat (4) @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_io_en", io_en, 0);
      chk("idle_dqs_en", dqs_en, 0);
      chk("idle_dqs_out", dqs_out, 0);
   endtask

   // read-side latency: outputs stay off until the last latency beat, then drive with dqs low
   task automatic read_latency(input int lat);
      if (lat > 0) begin
         chk("lat_pre_io_en", io_en, 0);
         for (int i = 0; i < lat - 1; i++) beat(8'h00, 0);
         chk("lat_last_io_en", io_en, 0);
         beat(8'h00, 0);
      end
      chk("drive_io_en", io_en, 1);
      chk("drive_dqs_en", dqs_en, 1);
      chk("drive_dqs_out", dqs_out, 0);
   endtask

   task automatic do_write(input logic [31:0] a, input int n);
      bit masked;
      int idx;
      start(8'h80, a);
      for (int i = 0; i < 2 * int'(mr_m[4]); i++) beat(8'h00, 0);
      for (int i = 0; i < n; i++) begin
         beat(wbuf[i], mbuf[i]);
`ifdef PSRAM_RESP_DQS_MASK_EN
         masked = mbuf[i];
`else
         masked = 1'b0;
`endif
         idx = int'((a + 32'(i)) % MB);
         if (!masked) begin mem_m[idx] = wbuf[i]; wr_m[idx] = 1'b1; end
      end
      chk("wr_io_en", io_en, 0);
      finish();
   endtask

   task automatic do_read(input logic [31:0] a, input int n);
      int idx;
      start(8'h00, a);
      read_latency(2 * int'(mr_m[0]));
      for (int i = 0; i < n; i++) begin
         beat(8'h00, 0);
         idx = int'((a + 32'(i)) % MB);
         if (wr_m[idx]) chk("rd_data", io_out, mem_m[idx]);
         chk("rd_dqs", dqs_out, (i % 2 == 0) ? 1 : 0);
      end
      finish();
   endtask

   task automatic do_mrw(input logic [2:0] idx, input logic [7:0] v);
      start(8'hC0, {29'h0, idx});
      for (int i = 0; i < 2 * int'(mr_m[4]); i++) beat(8'h00, 0);
      beat(v, 1);
      beat(~v, 0);
      if (idx != 3'd1) mr_m[idx] = v;
      finish();
   endtask

   task automatic do_mrr(input logic [2:0] idx, input int n);
      start(8'h40, {29'h0, idx});
      read_latency(2 * int'(mr_m[0]));
      for (int i = 0; i < n; i++) begin
         beat(8'h00, 0);
         chk("mrr_data", io_out, mr_m[idx]);
      end
      finish();
   endtask

   initial begin
      for (int i = 0; i < MB; i++) wr_m[i] = 1'b0;
      model_mr_reset();

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_io_out", io_out, 0);
      chk("rst_io_en", io_en, 0);
      chk("rst_dqs_out", dqs_out, 0);
      chk("rst_dqs_en", dqs_en, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      do_mrr(3'd0, 2);
      do_mrr(3'd1, 2);

      // write then read back with default latency 10 beats
      wbuf[0] = 8'hA1; wbuf[1] = 8'hB2; wbuf[2] = 8'hC3; wbuf[3] = 8'hD4;
      for (int i = 0; i < 4; i++) mbuf[i] = 1'b0;
      do_write(32'h100, 4);
      do_read(32'h100, 4);

      // MR0 = 3 shortens read latency; MR1 is read-only
      do_mrw(3'd0, 8'h03);
      do_read(32'h100, 4);
      do_mrw(3'd1, 8'hFF);
      do_mrr(3'd1, 1);

      // linear wrap at the top of the array
      wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
      do_write(32'(MB - 2), 3);
      do_read(32'(MB - 2), 3);
      do_read(32'h0, 1);

      // aborted write after two address beats
      @(negedge clk); ce = 1'b0; repeat (3) @(negedge clk);
      beat(8'h80, 0); beat(8'h00, 0); beat(8'h00, 0); beat(8'h00, 0);
      finish();
      do_read(32'h100, 4);

      // DQS write mask over a zeroed region
      for (int i = 0; i < 4; i++) begin wbuf[i] = 8'h00; mbuf[i] = 1'b0; end
      do_write(32'h300, 4);
      for (int i = 0; i < 4; i++) begin wbuf[i] = 8'hEE; mbuf[i] = (i % 2 == 1); end
      do_write(32'h300, 4);
      do_read(32'h300, 4);

      // unknown opcode never drives the bus
      start(8'h5A, 32'h0);
      for (int i = 0; i < 6; i++) begin
         beat(8'($urandom), 0);
         chk("ign_io_en", io_en, 0);
         chk("ign_dqs_en", dqs_en, 0);
      end
      finish();

      // randomized latencies, addresses, data and masks
      for (int it = 0; it < 8; it++) begin
         logic [31:0] a;
         int n;
         do_mrw(3'd0, 8'($urandom_range(0, 3)));
         do_mrw(3'd4, 8'($urandom_range(0, 3)));
         a = $urandom;
         n = $urandom_range(1, 6);
         for (int i = 0; i < n; i++) begin
            wbuf[i] = 8'($urandom);
            mbuf[i] = ($urandom_range(0, 3) == 0);
         end
         do_write(a, n);
         do_read(a, n);
         do_mrw(3'd2, 8'($urandom));
         do_mrr(3'd2, 2);
      end

      // reset in the middle of a write restores the MRs
      do_mrw(3'd0, 8'h02);
      start(8'h80, 32'h200);
      beat(8'h00, 0);
      @(negedge clk);
      rst = 1'b1; ce = 1'b1; sck = 1'b0;
      repeat (2) @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_io_en", io_en, 0);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      model_mr_reset();
      do_mrr(3'd0, 1);
      do_mrr(3'd4, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
